// File: rtl/rat_pkg.sv
// Shared definitions for the program-counter sequencer: flow-control
// opcodes, the sequencer state type and the PC DIN mux encodings.
package rat_pkg;

   // Flow-control opcodes, {ir[17:13], ir[1:0]}
   localparam logic [6:0] BRN   = 7'b0010000;
   localparam logic [6:0] CALL  = 7'b0010001;
   localparam logic [6:0] BREQ  = 7'b0010010;
   localparam logic [6:0] BRNE  = 7'b0010011;
   localparam logic [6:0] BRCS  = 7'b0010100;
   localparam logic [6:0] BRCC  = 7'b0010101;
   localparam logic [6:0] RET   = 7'b0110010;
   localparam logic [6:0] SEI   = 7'b0110100;
   localparam logic [6:0] CLI   = 7'b0110101;
   localparam logic [6:0] RETID = 7'b0110110;
   localparam logic [6:0] RETIE = 7'b0110111;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_INTR  = 2'd3
   } state_t;

   // PC DIN mux selects
   localparam logic [1:0] SEL_IMMED = 2'd0;
   localparam logic [1:0] SEL_STACK = 2'd1;
   localparam logic [1:0] SEL_VEC   = 2'd2;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the program counter strobes, the PC DIN
// mux select, the stack push/pop controls and the interrupt entry sequence.
// Every instruction takes FETCH + EXEC; a taken interrupt adds one INTR cycle.
module pc_sequencer
   import rat_pkg::*;
#(
   parameter logic [9:0] INT_VEC = 10'h3FF,
   parameter int         PC_W    = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] OPCODE,
   input  logic       C_FLAG,
   input  logic       Z_FLAG,
   input  logic       INTR,
   output logic       PC_RST,
   output logic       PC_LD,
   output logic       PC_INC,
   output logic [1:0] PC_MUX_SEL,
   output logic       SP_INCR,
   output logic       SP_DECR,
   output logic       SCR_WE,
   output logic       I_FLAG,
   output logic       FLG_SHAD_LD,
   output logic       FLG_SHAD_RESTORE
);

   // The vector itself is applied by the downstream DIN mux; here we only
   // guard that it fits the program counter it will be loaded into.
   if ((32'(INT_VEC) >> PC_W) != 32'd0) begin : g_vec_check
      $error("INT_VEC does not fit in PC_W bits");
   end

   state_t state;
   state_t state_nxt;
   logic   i_flag;
   logic   i_flag_nxt;
   logic   int_pend;
   logic   int_take;

   assign I_FLAG = i_flag;

   // State, interrupt-enable flag and accepted-interrupt marker
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= ST_INIT;
         i_flag   <= 1'b0;
         int_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         i_flag   <= i_flag_nxt;
         int_pend <= int_take;
      end
   end

   // Next state, I_FLAG update and all PC/stack strobes
   always_comb begin
      state_nxt        = ST_INIT;
      i_flag_nxt       = i_flag;
      int_take         = 1'b0;
      PC_RST           = 1'b0;
      PC_LD            = 1'b0;
      PC_INC           = 1'b0;
      PC_MUX_SEL       = SEL_IMMED;
      SP_INCR          = 1'b0;
      SP_DECR          = 1'b0;
      SCR_WE           = 1'b0;
      FLG_SHAD_LD      = 1'b0;
      FLG_SHAD_RESTORE = 1'b0;

      case (state)
         ST_INIT: begin
            PC_RST    = 1'b1;
            state_nxt = ST_FETCH;
         end

         ST_FETCH: begin
            PC_INC    = 1'b1;
            state_nxt = ST_EXEC;
         end

         ST_EXEC: begin
            case (OPCODE)
               BRN:  PC_LD = 1'b1;
               BREQ: PC_LD = Z_FLAG;
               BRNE: PC_LD = !Z_FLAG;
               BRCS: PC_LD = C_FLAG;
               BRCC: PC_LD = !C_FLAG;
               CALL: begin
                  PC_LD   = 1'b1;
                  SP_DECR = 1'b1;
                  SCR_WE  = 1'b1;
               end
               RET: begin
                  PC_LD      = 1'b1;
                  PC_MUX_SEL = SEL_STACK;
                  SP_INCR    = 1'b1;
               end
               RETID, RETIE: begin
                  PC_LD            = 1'b1;
                  PC_MUX_SEL       = SEL_STACK;
                  SP_INCR          = 1'b1;
                  FLG_SHAD_RESTORE = 1'b1;
                  i_flag_nxt       = OPCODE[0];
               end
               SEI: i_flag_nxt = 1'b1;
               CLI: i_flag_nxt = 1'b0;
               default: ;
            endcase
            // The enable seen here is the registered one, so an SEI in
            // this very cycle cannot admit an interrupt until the next EXEC.
            int_take  = INTR && i_flag;
            state_nxt = int_take ? ST_INTR : ST_FETCH;
         end

         ST_INTR: begin
            // Push the already-updated PC and jump to the vector
            PC_LD       = int_pend;
            PC_MUX_SEL  = int_pend ? SEL_VEC : SEL_IMMED;
            SP_DECR     = int_pend;
            SCR_WE      = int_pend;
            FLG_SHAD_LD = int_pend;
            i_flag_nxt  = 1'b0;
            state_nxt   = ST_FETCH;
         end

         default: state_nxt = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a fixed table of EXEC vectors, hand sequences for
// the interrupt and reset corners, and a random instruction stream checked
// against an instruction-level reference model.
module tb_pc_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [6:0] OPCODE = 7'd0;
   logic       C_FLAG = 1'b0;
   logic       Z_FLAG = 1'b0;
   logic       INTR = 1'b0;
   logic       PC_RST, PC_LD, PC_INC, SP_INCR, SP_DECR, SCR_WE;
   logic       I_FLAG, FLG_SHAD_LD, FLG_SHAD_RESTORE;
   logic [1:0] PC_MUX_SEL;

   int npass = 0;
   int ntotal = 0;
   logic iflag_m = 1'b0;

   pc_sequencer dut (
      .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
      .INTR(INTR), .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC),
      .PC_MUX_SEL(PC_MUX_SEL), .SP_INCR(SP_INCR), .SP_DECR(SP_DECR),
      .SCR_WE(SCR_WE), .I_FLAG(I_FLAG), .FLG_SHAD_LD(FLG_SHAD_LD),
      .FLG_SHAD_RESTORE(FLG_SHAD_RESTORE)
   );

   always #5 CLK = ~CLK;

   // Output vector: {pc_rst, ld, inc, sel[1:0], sp_incr, sp_decr, scr_we, shad_ld, restore}
   function automatic logic [9:0] mk(logic ld, logic [1:0] sel, logic incr,
                                     logic decr, logic we, logic shld, logic rest);
      return {1'b0, ld, 1'b0, sel, incr, decr, we, shld, rest};
   endfunction

   localparam logic [9:0] O_INIT  = 10'b1000000000;
   localparam logic [9:0] O_FETCH = 10'b0010000000;
   localparam logic [9:0] O_NONE  = 10'b0000000000;

   function automatic logic [9:0] o_intr();
      return mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   endfunction

   // Reference behaviour of one EXEC cycle, straight from the opcode list
   function automatic logic [9:0] exp_exec(logic [6:0] op, logic c, logic z);
      case (op)
         7'b0010000: return mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         7'b0010010: return z  ? mk(1'b1, 2'd0, 0, 0, 0, 0, 0) : O_NONE;
         7'b0010011: return !z ? mk(1'b1, 2'd0, 0, 0, 0, 0, 0) : O_NONE;
         7'b0010100: return c  ? mk(1'b1, 2'd0, 0, 0, 0, 0, 0) : O_NONE;
         7'b0010101: return !c ? mk(1'b1, 2'd0, 0, 0, 0, 0, 0) : O_NONE;
         7'b0010001: return mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         7'b0110010: return mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         7'b0110110,
         7'b0110111: return mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         default:    return O_NONE;
      endcase
   endfunction

   function automatic logic next_iflag(logic [6:0] op, logic cur);
      case (op)
         7'b0110100, 7'b0110111: return 1'b1;
         7'b0110101, 7'b0110110: return 1'b0;
         default:                return cur;
      endcase
   endfunction

   function automatic logic [9:0] dut_outs();
      return {PC_RST, PC_LD, PC_INC, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE,
              FLG_SHAD_LD, FLG_SHAD_RESTORE};
   endfunction

   // Sample mid-cycle, then move to just after the next rising edge
   task automatic check_cycle(input string name, input logic [9:0] exp_o,
                              input logic exp_i);
      @(negedge CLK);
      ntotal++;
      if (dut_outs() === exp_o) npass++;
      else $display("FAIL %s outputs: got %b want %b (t=%0t)", name, dut_outs(), exp_o, $time);
      ntotal++;
      if (I_FLAG === exp_i) npass++;
      else $display("FAIL %s I_FLAG: got %b want %b (t=%0t)", name, I_FLAG, exp_i, $time);
      @(posedge CLK);
      #1;
   endtask

   // One instruction through the model: FETCH, EXEC, optional INTR
   task automatic do_instr(input string name, input logic [6:0] op,
                           input logic c, input logic z, input logic intr);
      logic taken;
      OPCODE = 7'($urandom);
      C_FLAG = 1'($urandom);
      Z_FLAG = 1'($urandom);
      INTR   = intr;
      check_cycle({name, "_fetch"}, O_FETCH, iflag_m);
      OPCODE = op;
      C_FLAG = c;
      Z_FLAG = z;
      taken  = intr && iflag_m;
      check_cycle({name, "_exec"}, exp_exec(op, c, z), iflag_m);
      iflag_m = next_iflag(op, iflag_m);
      if (taken) begin
         OPCODE = 7'($urandom);
         check_cycle({name, "_intr"}, o_intr(), iflag_m);
         iflag_m = 1'b0;
      end
   endtask

   typedef struct {
      logic [6:0] op;
      logic       c;
      logic       z;
      logic [9:0] exp;
      logic       exp_if;
   } vec_t;

   vec_t tbl[17];
   logic [6:0] ops[11];

   initial begin
      tbl[0]  = '{7'b0010000, 1'b0, 1'b0, mk(1, 2'd0, 0, 0, 0, 0, 0), 1'b0};
      tbl[1]  = '{7'b0010010, 1'b0, 1'b1, mk(1, 2'd0, 0, 0, 0, 0, 0), 1'b0};
      tbl[2]  = '{7'b0010010, 1'b1, 1'b0, O_NONE,                     1'b0};
      tbl[3]  = '{7'b0010011, 1'b0, 1'b0, mk(1, 2'd0, 0, 0, 0, 0, 0), 1'b0};
      tbl[4]  = '{7'b0010011, 1'b0, 1'b1, O_NONE,                     1'b0};
      tbl[5]  = '{7'b0010100, 1'b1, 1'b0, mk(1, 2'd0, 0, 0, 0, 0, 0), 1'b0};
      tbl[6]  = '{7'b0010100, 1'b0, 1'b1, O_NONE,                     1'b0};
      tbl[7]  = '{7'b0010101, 1'b0, 1'b0, mk(1, 2'd0, 0, 0, 0, 0, 0), 1'b0};
      tbl[8]  = '{7'b0010101, 1'b1, 1'b0, O_NONE,                     1'b0};
      tbl[9]  = '{7'b0010001, 1'b0, 1'b0, mk(1, 2'd0, 0, 1, 1, 0, 0), 1'b0};
      tbl[10] = '{7'b0110010, 1'b0, 1'b0, mk(1, 2'd1, 1, 0, 0, 0, 0), 1'b0};
      tbl[11] = '{7'b0110100, 1'b0, 1'b0, O_NONE,                     1'b1};
      tbl[12] = '{7'b0110101, 1'b0, 1'b0, O_NONE,                     1'b0};
      tbl[13] = '{7'b0110111, 1'b0, 1'b0, mk(1, 2'd1, 1, 0, 0, 0, 1), 1'b1};
      tbl[14] = '{7'b0110110, 1'b0, 1'b0, mk(1, 2'd1, 1, 0, 0, 0, 1), 1'b0};
      tbl[15] = '{7'b0000000, 1'b1, 1'b1, O_NONE,                     1'b0};
      tbl[16] = '{7'b1111111, 1'b1, 1'b1, O_NONE,                     1'b0};
      ops = '{7'b0010000, 7'b0010010, 7'b0010011, 7'b0010100, 7'b0010101,
              7'b0010001, 7'b0110010, 7'b0110110, 7'b0110111, 7'b0110100,
              7'b0110101};

      // Reset held for two edges, then the INIT cycle
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      check_cycle("reset_init", O_INIT, 1'b0);
      iflag_m = 1'b0;

      // Table of EXEC vectors, interrupts idle
      for (int i = 0; i < 17; i++) begin
         INTR   = 1'b0;
         OPCODE = 7'($urandom);
         check_cycle($sformatf("tbl%0d_fetch", i), O_FETCH, iflag_m);
         OPCODE = tbl[i].op;
         C_FLAG = tbl[i].c;
         Z_FLAG = tbl[i].z;
         check_cycle($sformatf("tbl%0d_exec", i), tbl[i].exp, iflag_m);
         iflag_m = tbl[i].exp_if;
      end

      // BREQ taken then not taken, CALL then RET
      do_instr("breq_z1", 7'b0010010, 1'b0, 1'b1, 1'b0);
      do_instr("breq_z0", 7'b0010010, 1'b0, 1'b0, 1'b0);
      do_instr("call", 7'b0010001, 1'b0, 1'b0, 1'b0);
      do_instr("ret", 7'b0110010, 1'b0, 1'b0, 1'b0);

      // SEI with INTR held: taken one instruction later, then no re-entry
      do_instr("sei_intr", 7'b0110100, 1'b0, 1'b0, 1'b1);
      do_instr("nop_take", 7'b0000000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_instr("no_reentry", 7'b0000000, 1'b0, 1'b0, 1'b1);

      // INTR held while disabled, then RETIE enables it
      for (int i = 0; i < 10; i++) do_instr("masked", 7'b0000000, 1'b0, 1'b0, 1'b1);
      do_instr("retie", 7'b0110111, 1'b0, 1'b0, 1'b1);
      do_instr("after_retie", 7'b0000000, 1'b0, 1'b0, 1'b1);

      // Reset asserted during the interrupt entry cycle
      do_instr("sei2", 7'b0110100, 1'b0, 1'b0, 1'b0);
      INTR   = 1'b1;
      OPCODE = 7'd0;
      check_cycle("rst_fetch", O_FETCH, 1'b1);
      check_cycle("rst_exec", O_NONE, 1'b1);
      RST = 1'b0;
      check_cycle("rst_intr", o_intr(), 1'b1);
      RST = 1'b1;
      INTR = 1'b0;
      check_cycle("rst_abort_init", O_INIT, 1'b0);
      iflag_m = 1'b0;

      // Random instruction stream against the model
      for (int i = 0; i < 300; i++) begin
         logic [6:0] op;
         if ($urandom_range(0, 4) == 0) op = 7'($urandom);
         else op = ops[$urandom_range(0, 10)];
         do_instr("rand", op, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
